// File: rtl/spi_fifo_sequencer.sv
// Byte sequencer: pops the input FIFO, runs one spimaster transfer per byte, pushes the reply.
// Define SPI_SEQ_TIMEOUT_EN to add a sticky watchdog on the spimaster handshake phases.
module spi_fifo_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   in_nempty,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   in_pop,
    input  logic                   out_full,
    output logic                   out_shift,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   spi_go,
    input  logic                   spi_state,
    output logic [DATA_WIDTH-1:0]  spi_din,
    input  logic [DATA_WIDTH-1:0]  spi_dout,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] xfer_count,
    output logic                   timeout,
    input  logic                   clear_err
);
    typedef enum logic [2:0] {IDLE, START, WAIT_ACK, WAIT_DONE, PUSH} state_t;

    state_t state, state_nx;
    logic   start_ok, phase_exp, timed_out;

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] phase_cnt;

    assign phase_exp = (phase_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign start_ok  = !timeout;

    // Phase counter restarts on every state change; a set on the same edge as clear_err wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            if (state_nx != state)
                phase_cnt <= '0;
            else if (state == WAIT_ACK || state == WAIT_DONE)
                phase_cnt <= phase_cnt + TW'(1);
            if (timed_out)
                timeout <= 1'b1;
            else if (clear_err)
                timeout <= 1'b0;
        end
    end
`else
    logic unused_cfg;

    assign phase_exp  = 1'b0;
    assign start_ok   = 1'b1;
    assign timeout    = 1'b0;
    assign unused_cfg = clear_err ^ timed_out ^ (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_nx  = state;
        timed_out = 1'b0;
        case (state)
            IDLE:
                if (enable && in_nempty && !out_full && start_ok) state_nx = START;
            START:
                state_nx = WAIT_ACK;
            WAIT_ACK:
                if (spi_state) state_nx = WAIT_DONE;
                else if (phase_exp) begin
                    state_nx  = IDLE;
                    timed_out = 1'b1;
                end
            WAIT_DONE:
                if (!spi_state) state_nx = PUSH;
                else if (phase_exp) begin
                    state_nx  = IDLE;
                    timed_out = 1'b1;
                end
            PUSH:
                state_nx = IDLE;
            default:
                state_nx = IDLE;
        endcase
    end

    // Strobes are registered from the transition, so each lands in the cycle after its decision.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            in_pop     <= 1'b0;
            out_shift  <= 1'b0;
            spi_go     <= 1'b0;
            busy       <= 1'b0;
            spi_din    <= '0;
            out_data   <= '0;
            xfer_count <= '0;
        end else begin
            state     <= state_nx;
            in_pop    <= (state == IDLE) && (state_nx == START);
            spi_go    <= (state == START);
            out_shift <= (state == WAIT_DONE) && (state_nx == PUSH);
            busy      <= (state_nx != IDLE);
            if (state == IDLE && state_nx == START)
                spi_din <= in_data;
            if (state == WAIT_DONE && state_nx == PUSH) begin
                out_data   <= spi_dout;
                xfer_count <= xfer_count + COUNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_spi_fifo_sequencer.sv
// Bench for spi_fifo_sequencer: queue-based FIFO/spimaster models plus a pop/push scoreboard.
module tb_spi_fifo_sequencer;
    localparam int DW = 8;
    localparam int CW = 16;

    logic          clock = 1'b0, reset = 1'b1;
    logic          enable = 1'b0, in_nempty = 1'b0, out_full = 1'b0, spi_state = 1'b0, clear_err = 1'b0;
    logic [DW-1:0] in_data = '0, spi_dout = '0;
    logic          in_pop, out_shift, spi_go, busy, timeout;
    logic [DW-1:0] out_data, spi_din;
    logic [CW-1:0] xfer_count;
    logic          unused_w_pop, unused_w_shift, unused_w_go, unused_w_busy, unused_w_to;
    logic [DW-1:0] w_out_data, unused_w_din;
    logic [3:0]    w_xfer_count;

    always #5 clock = ~clock;

    spi_fifo_sequencer #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset), .enable(enable), .in_nempty(in_nempty), .in_data(in_data),
        .in_pop(in_pop), .out_full(out_full), .out_shift(out_shift), .out_data(out_data),
        .spi_go(spi_go), .spi_state(spi_state), .spi_din(spi_din), .spi_dout(spi_dout),
        .busy(busy), .xfer_count(xfer_count), .timeout(timeout), .clear_err(clear_err));

    // Narrow-counter twin so counter wrap is reached within the run.
    spi_fifo_sequencer #(.DATA_WIDTH(DW), .COUNT_WIDTH(4), .TIMEOUT_CYCLES(8)) dut_w (
        .clock(clock), .reset(reset), .enable(enable), .in_nempty(in_nempty), .in_data(in_data),
        .in_pop(unused_w_pop), .out_full(out_full), .out_shift(unused_w_shift), .out_data(w_out_data),
        .spi_go(unused_w_go), .spi_state(spi_state), .spi_din(unused_w_din), .spi_dout(spi_dout),
        .busy(unused_w_busy), .xfer_count(w_xfer_count), .timeout(unused_w_to), .clear_err(clear_err));

    typedef struct { logic [7:0] data; int ack; int bsy; logic [7:0] exp_out; } vec_t;
    vec_t tbl [6];

    int            errors = 0, checks = 0;
    logic [DW-1:0] in_q[$], exp_q[$], got_q[$];
    logic [DW-1:0] mask = '0, got_last = '0, spi_tx = '0;
    logic [CW-1:0] model_cnt = '0;
    int            cyc = 0, pops = 0, gos = 0, shifts = 0, last_pop_cyc = -10;
    int            ack_wait = 0, busy_left = 0, cur_ack = 1, cur_busy = 3;
    bit            spi_active = 0, stuck = 0, rnd_spi = 0, model_to = 0;
    int            p0, g0, s0;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fifo_sync();
        in_nempty = (in_q.size() != 0);
        in_data   = in_nempty ? in_q[0] : '0;
    endtask

    task automatic push(input logic [7:0] b);
        in_q.push_back(b);
        fifo_sync();
    endtask

    // One cycle: sample DUT at negedge, check, then advance the FIFO and spimaster models.
    task automatic tick();
        @(negedge clock);
        cyc++;
        chk("timeout_flag", 32'(timeout), 32'(model_to));
        if (in_pop) begin
            chk("pop_gate", 32'({enable, out_full, in_q.size() != 0, timeout}), 32'(4'b1010));
            chk("one_in_flight", exp_q.size(), 0);
            pops++;
            last_pop_cyc = cyc;
            if (in_q.size() != 0) exp_q.push_back(in_q.pop_front() ^ mask);
        end
        if (spi_go) begin
            gos++;
            chk("go_after_pop", cyc - last_pop_cyc, 1);
            if (exp_q.size() != 0) chk("go_din", 32'(spi_din), 32'(exp_q[0] ^ mask));
            if (!stuck) begin
                spi_active = 1;
                spi_tx     = spi_din;
                ack_wait   = rnd_spi ? int'($urandom_range(0, 3)) : cur_ack;
                busy_left  = rnd_spi ? int'($urandom_range(0, 5)) : cur_busy;
            end
        end else if (spi_active) begin
            if (ack_wait > 0) ack_wait--;
            else if (!spi_state) spi_state = 1'b1;
            else if (busy_left > 0) busy_left--;
            else begin
                chk("din_stable", 32'(spi_din), 32'(spi_tx));
                spi_state  = 1'b0;
                spi_dout   = spi_tx ^ mask;
                spi_active = 0;
            end
        end
        if (out_shift) begin
            shifts++;
            model_cnt++;
            got_last = out_data;
            got_q.push_back(out_data);
            if (exp_q.size() == 0) chk("spurious_shift", 32'(out_shift), 0);
            else begin
                chk("out_data", 32'(out_data), 32'(exp_q[0]));
                chk("wrap_data", 32'(w_out_data), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
            chk("xfer_count", 32'(xfer_count), 32'(model_cnt));
            chk("wrap_count", 32'(w_xfer_count), 32'(model_cnt[3:0]));
            chk("busy_push", 32'(busy), 1);
        end
        fifo_sync();
    endtask

    task automatic wait_idle(input int limit);
        bit done = 0;
        for (int n = 0; n < limit && !done; n++) begin
            tick();
            done = !busy && !spi_active && exp_q.size() == 0 &&
                   (in_q.size() == 0 || !enable || out_full);
        end
        chk("settle", 32'(done), 1);
    endtask

    task automatic wait_for_go(input int limit);
        bit seen = 0;
        for (int n = 0; n < limit && !seen; n++) begin
            tick();
            seen = spi_go;
        end
        chk("go_seen", 32'(seen), 1);
    endtask

    task automatic model_reset();
        spi_active = 0;
        spi_state  = 1'b0;
        exp_q.delete();
        model_cnt  = '0;
        model_to   = 0;
    endtask

    initial begin
        tbl = '{'{8'hA5, 1, 3, 8'hA5}, '{8'h00, 0, 0, 8'h00}, '{8'hFF, 3, 1, 8'hFF},
                '{8'h3C, 0, 6, 8'h3C}, '{8'h81, 2, 2, 8'h81}, '{8'h5A, 1, 0, 8'h5A}};

        // Reset values
        tick();
        chk("rst_strobes", 32'({in_pop, out_shift, spi_go, busy, timeout}), 0);
        chk("rst_data", {out_data, spi_din, xfer_count}, 0);
        reset = 1'b0;
        tick();

        // Single transfers with varied spimaster timing
        for (int i = 0; i < 6; i++) begin
            cur_ack  = tbl[i].ack;
            cur_busy = tbl[i].bsy;
            p0 = pops; s0 = shifts;
            push(tbl[i].data);
            enable = 1'b1;
            wait_idle(60);
            enable = 1'b0;
            chk("tbl_out", 32'(got_last), 32'(tbl[i].exp_out));
            chk("tbl_pops", pops - p0, 1);
            chk("tbl_shifts", shifts - s0, 1);
            chk("tbl_count", 32'(xfer_count), i + 1);
        end

        // Burst 01..10 keeps order
        cur_ack = 1; cur_busy = 2;
        got_q.delete();
        for (int i = 1; i <= 16; i++) push(8'(i));
        enable = 1'b1;
        wait_idle(400);
        chk("burst_len", got_q.size(), 16);
        for (int i = 0; i < 16 && i < got_q.size(); i++) chk("burst_order", 32'(got_q[i]), i + 1);
        chk("burst_count", 32'(xfer_count), 22);

        // Backpressure: nothing starts while out_full, then pop at N+1 and go at N+2
        out_full = 1'b1;
        push(8'h33); push(8'h44);
        p0 = pops; g0 = gos;
        repeat (6) tick();
        chk("bp_no_pop", pops - p0, 0);
        chk("bp_no_go", gos - g0, 0);
        chk("bp_idle", 32'(busy), 0);
        out_full = 1'b0;
        tick();
        chk("bp_pop_n1", 32'(in_pop), 1);
        tick();
        chk("bp_go_n2", 32'({spi_go, in_pop}), 32'(2'b10));
        wait_idle(100);

        // Enable drop right after spi_go finishes the current byte only
        enable = 1'b0;
        push(8'h71); push(8'h72); push(8'h73);
        p0 = pops; s0 = shifts;
        enable = 1'b1;
        wait_for_go(10);
        enable = 1'b0;
        wait_idle(60);
        chk("en_pops", pops - p0, 1);
        chk("en_shifts", shifts - s0, 1);
        chk("en_left", in_q.size(), 2);
        enable = 1'b1;
        wait_idle(100);

        // Randomized traffic with a non-loopback spimaster reply
        mask = 8'h5A; rnd_spi = 1;
        s0 = shifts;
        for (int i = 0; i < 150; i++) push(8'($urandom));
        for (int n = 0; n < 5000 && in_q.size() != 0; n++) begin
            tick();
            enable   = ($urandom_range(0, 9) < 8);
            out_full = ($urandom_range(0, 9) < 2);
        end
        enable = 1'b1; out_full = 1'b0;
        wait_idle(200);
        chk("rnd_drained", in_q.size(), 0);
        chk("rnd_shifts", shifts - s0, 150);
        mask = '0; rnd_spi = 0; enable = 1'b0;

        // Asynchronous reset while spimaster is busy
        cur_ack = 0; cur_busy = 20;
        push(8'hC3);
        enable = 1'b1;
        for (int n = 0; n < 20 && !spi_state; n++) tick();
        repeat (3) tick();
        enable = 1'b0;
        chk("ar_busy_before", 32'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_strobes", 32'({in_pop, out_shift, spi_go, busy, timeout}), 0);
        chk("ar_data", {out_data, spi_din, xfer_count}, 0);
        model_reset();
        tick();
        reset = 1'b0;
        cur_ack = 1; cur_busy = 2;

        // Spimaster never acknowledges
        stuck = 1;
        push(8'h99);
        enable = 1'b1;
        wait_for_go(10);
`ifdef SPI_SEQ_TIMEOUT_EN
        repeat (7) tick();
        chk("to_still_waiting", 32'(busy), 1);
        model_to = 1;
        tick();
        chk("to_abort_idle", 32'(busy), 0);
        exp_q.delete();
        stuck = 0;
        p0 = pops; s0 = shifts;
        push(8'h9A);
        repeat (5) tick();
        chk("to_blocks_start", pops - p0, 0);
        clear_err = 1'b1;
        model_to  = 0;
        tick();
        clear_err = 1'b0;
        wait_idle(60);
        chk("to_resume_shift", shifts - s0, 1);
        chk("to_resume_data", 32'(got_last), 32'h9A);
`else
        repeat (20) tick();
        chk("stuck_waits", 32'({busy, timeout}), 32'(2'b10));
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
        stuck = 0;
        s0 = shifts;
        push(8'h5E);
        wait_idle(60);
        chk("stuck_recover", 32'(got_last), 32'h5E);
        chk("stuck_recover_n", shifts - s0, 1);
`endif
        enable = 1'b0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
